// File: rtl/miner_pkg.sv
// Shared miner definitions: nonce type, default hit FIFO depth and the
// count-based occupancy classification used by the hit FIFO.
package miner_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned HIT_FIFO_DEPTH = 4;

  typedef logic [NONCE_W-1:0] nonce_t;

  // Occupancy class derived purely from the entry count.
  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  // Classify an occupancy count against the FIFO depth.
  function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
    occ_e occ;
    if (cnt == 0) begin
      occ = OccEmpty;
    end else if (cnt >= depth) begin
      occ = OccFull;
    end else begin
      occ = OccPartial;
    end
    return occ;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Generic first-word-fall-through register-array FIFO.
// full/empty are derived from the occupancy count, never from pointer
// equality, so the pointers can be plain power-of-two wrapping counters.
// A push while full is accepted only when a pop frees a slot that same cycle.
// DEPTH must be a power of two and at least 2.
module hit_fifo
  import miner_pkg::*;
#(
  parameter int unsigned WIDTH = NONCE_W,
  parameter int unsigned DEPTH = HIT_FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  occ_e occ;
  logic push_ok;
  logic pop_ok;

  // Occupancy class and qualified push/pop strobes.
  always_comb begin
    occ     = occ_of(int'(count_q), DEPTH);
    empty   = (occ == OccEmpty);
    full    = (occ == OccFull);
    pop_ok  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    push_ok = push & (~full | pop_ok);
  end

  // Next-state for storage, pointers and count; clear overrides everything.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Head falls through; forced to zero while empty so stale data never leaks.
  always_comb begin
    count = count_q;
    rdata = empty ? '0 : mem_q[rptr_q];
  end

`ifndef SYNTHESIS
  // Occupancy can never exceed the array size.
  assert property (@(posedge clk) disable iff (!n_rst) count_q <= CNT_W'(DEPTH));

  // Head is held while it is waiting to be accepted.
  assert property (@(posedge clk) disable iff (!n_rst)
                   (!empty && !pop && !clear) |=> $stable(rdata));
`endif

endmodule

// File: rtl/hit_capture.sv
// Winner capture stage after the target comparator.
// Qualifies the comparator result with the SHA-done strobe, buffers the nonce of
// every winning hash in a FWFT FIFO offered over valid/ready, and raises a
// sticky overflow flag when a winner is dropped because the FIFO is full.
// Optional feature: define HIT_CAPTURE_STATS_EN to add a saturating 32-bit
// hit_count output that counts every qualified hit, dropped ones included.
module hit_capture
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_W = miner_pkg::NONCE_W,
  parameter int unsigned DEPTH   = HIT_FIFO_DEPTH,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic               hash_done,
  input  logic               valid,
  input  logic [NONCE_W-1:0] nonce_in,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count,
`ifdef HIT_CAPTURE_STATS_EN
  output logic [31:0]        hit_count,
`endif
  output logic               overflow
);

  logic hit;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic overflow_q, overflow_d;

  // Hit qualification and consumer handshake.
  always_comb begin
    hit       = hash_done & valid;
    out_valid = ~fifo_empty;
    pop       = out_valid & out_ready;
  end

  hit_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (DEPTH)
  ) u_hit_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .push  (hit),
    .wdata (nonce_in),
    .pop   (pop),
    .rdata (out_nonce),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overflow sets on a hit that finds the FIFO full with no pop making room.
  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (hit && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef HIT_CAPTURE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;

  // Saturating hit counter; clear beats a same-cycle hit.
  always_comb begin
    hit_count_d = hit_count_q;
    if (clear) begin
      hit_count_d = '0;
    end else if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
  end

  // Hit counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hit_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_hit_capture.sv
// Self-checking bench for hit_capture: a queue-based reference model compared
// against the DUT on every falling edge, plus hand-computed spot checks.
module tb_hit_capture;

  localparam int unsigned NW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          n_rst;
  logic          clear;
  logic          hash_done;
  logic          valid;
  logic [NW-1:0] nonce_in;
  logic [NW-1:0] out_nonce;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef HIT_CAPTURE_STATS_EN
  logic [31:0]   hit_count;
`endif

  int vectors;
  int miscompares;

  hit_capture #(
    .NONCE_W (NW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .hash_done (hash_done),
    .valid     (valid),
    .nonce_in  (nonce_in),
    .out_nonce (out_nonce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
`ifdef HIT_CAPTURE_STATS_EN
    .hit_count (hit_count),
`endif
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending nonces, a sticky flag, a hit tally.
  logic [NW-1:0] mq[$];
  logic          m_ovf;
  logic [31:0]   m_hits;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_hits = 32'd0;
    end else if (clear) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_hits = 32'd0;
    end else begin
      if (hash_done && valid && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (hash_done && valid) begin
        if (mq.size() < DEPTH) mq.push_back(nonce_in);
        else m_ovf = 1'b1;
      end
    end
  end

  // Every-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [NW-1:0] exp_nonce;
    exp_nonce = (mq.size() > 0) ? mq[0] : '0;
    vectors++;
    if (out_valid !== (mq.size() > 0)) begin
      miscompares++;
      $display("FAIL model out_valid t=%0t got %b want %b", $time, out_valid, mq.size() > 0);
    end
    if (out_nonce !== exp_nonce) begin
      miscompares++;
      $display("FAIL model out_nonce t=%0t got %h want %h", $time, out_nonce, exp_nonce);
    end
    if (count !== CW'(mq.size())) begin
      miscompares++;
      $display("FAIL model count t=%0t got %0d want %0d", $time, count, mq.size());
    end
    if (overflow !== m_ovf) begin
      miscompares++;
      $display("FAIL model overflow t=%0t got %b want %b", $time, overflow, m_ovf);
    end
`ifdef HIT_CAPTURE_STATS_EN
    if (hit_count !== m_hits) begin
      miscompares++;
      $display("FAIL model hit_count t=%0t got %0d want %0d", $time, hit_count, m_hits);
    end
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the rising edge.
  task automatic cyc(input logic hd, input logic v, input logic [NW-1:0] n,
                     input logic rdy, input logic clr);
    hash_done = hd;
    valid     = v;
    nonce_in  = n;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    #1;
    hash_done = 1'b0;
    valid     = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst       = 1'b0;
    clear       = 1'b0;
    hash_done   = 1'b1;
    valid       = 1'b1;
    nonce_in    = 32'hDEAD_BEEF;
    out_ready   = 1'b0;

    // 1. Reset dominates a qualified hit.
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset out_nonce", out_nonce, 32'd0);
    hash_done = 1'b0;
    valid     = 1'b0;
    n_rst     = 1'b1;
    @(posedge clk);
    #1;

    // 2. Single hit, held without ready.
    cyc(1'b1, 1'b1, 32'h0000_00A5, 1'b0, 1'b0);
    chk("single out_valid", 32'(out_valid), 32'd1);
    chk("single out_nonce", out_nonce, 32'h0000_00A5);
    chk("single count", 32'(count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      chk("hold out_nonce", out_nonce, 32'h0000_00A5);
    end
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("drain single count", 32'(count), 32'd0);

    // 3. valid without hash_done is ignored.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
    chk("qual count", 32'(count), 32'd0);

    // 4. Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill count", 32'(count), 32'd4);
    cyc(1'b1, 1'b1, 32'd5, 1'b0, 1'b0);
    chk("ovf flag", 32'(overflow), 32'd1);
    chk("ovf count", 32'(count), 32'd4);
`ifdef HIT_CAPTURE_STATS_EN
    chk("stats incl dropped", hit_count, 32'd6);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("drain head", out_nonce, 32'(i));
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain count", 32'(count), 32'd0);
    chk("drain ovf sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("ready on empty", 32'(count), 32'd0);

    // 5. Full with simultaneous hit and pop.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'd9, 1'b1, 1'b0);
    chk("full hit+pop count", 32'(count), 32'd4);
    chk("full hit+pop ovf", 32'(overflow), 32'd0);
    chk("full hit+pop head", out_nonce, 32'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("nine last count", 32'(count), 32'd0);

    // Empty with hit and pop together: pop is void.
    cyc(1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
    chk("empty hit+pop count", 32'(count), 32'd1);
    chk("empty hit+pop head", out_nonce, 32'h55);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 6. Clear beats a same-cycle hit.
    cyc(1'b1, 1'b1, 32'd21, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'd22, 1'b0, 1'b0);
    chk("pre-clear count", 32'(count), 32'd2);
    cyc(1'b1, 1'b1, 32'd23, 1'b1, 1'b1);
    chk("clear count", 32'(count), 32'd0);
    chk("clear out_valid", 32'(out_valid), 32'd0);
    chk("clear ovf", 32'(overflow), 32'd0);
`ifdef HIT_CAPTURE_STATS_EN
    chk("clear hit_count", hit_count, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'(30 + i), 1'b1, 1'b0);
    chk("hit_count after 3", hit_count, 32'd3);
`endif

    // Async reset mid-stream empties immediately.
    cyc(1'b1, 1'b1, 32'd40, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'd41, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async rst count", 32'(count), 32'd0);
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc(1'b1, 1'b1, 32'd50, 1'b0, 1'b0);
    chk("post rst head", out_nonce, 32'd50);
    repeat (2) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
